passage_builder: RTL and testbench
==================================

Name: passage_builder

Overview:
- Sequencer that owns the word dictionary lookup port and assembles a random 25-character target passage for a typing round.
- On a build request it picks word ids with an internal LFSR and reads each word from the dictionary.
- Packs accepted words, separated by spaces, into a character buffer that the scoring/count logic and the VGA renderer consume.
- Sits between the round controller (issues the request) and the dictionary (a combinational id→word/length ROM).

Parameters:
- SLOTS, 25, passage capacity in characters; passage bus is 5*SLOTS bits.
- MAX_WORDS, 8, maximum words per passage.
- MAX_REJECT, 8, consecutive rejected picks before the build terminates.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  1  one-cycle build request (debounced/one-pulsed upstream)
- dict_id  out  5  dictionary word id
- dict_word  in  75  word characters, char k at [5k+4:5k], 15 chars max
- dict_len  in  4  word length in characters, 0..15
- passage  out  5*SLOTS  char i at [5i+4:5i]; 0=empty, 1..26=a..z, 27=space
- passage_len  out  5  valid characters in passage
- busy  out  1  build in progress
- done  out  1  one-cycle pulse when the build completes

Behaviour:
- Reset (async, active-high): FSM=IDLE; passage=0; passage_len=0; dict_id=0; busy=0; done=0; LFSR=LFSR_SEED; all counters 0.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, free-running, advances every clock including IDLE. Candidate id = lfsr[4:0].
- States:
  - IDLE: busy=0. On req → clear passage, pos, word_cnt and reject_cnt; go to PICK.
  - PICK: register dict_id = candidate; go to FETCH.
  - FETCH: one-cycle settle; latch dict_word/dict_len into local registers. Then evaluate in order:
    - If len==0: reject_cnt++. If reject_cnt reaches MAX_REJECT go DONE, else go PICK.
    - Else set need = len + (word_cnt!=0 ? 1 : 0). If pos+need > SLOTS go DONE (no partial words).
    - Else reset reject_cnt to 0. Go SPACE if word_cnt!=0, else COPY with k=0.
  - SPACE: write 27 at slot pos; pos++; go COPY with k=0.
  - COPY: write latched char k at slot pos; pos++; k++. When k==len-1 is written: word_cnt++. Then go DONE if word_cnt==MAX_WORDS or pos==SLOTS, else go PICK.
  - DONE: passage_len=pos; done=1 for exactly this cycle; go IDLE.
- Timing: busy=1 from the cycle after req through the DONE cycle inclusive. Per-word cost is 2 cycles plus a space cycle (except the first word) plus len cycles.
- Widths: pos is 5 bits and never exceeds SLOTS. The pos+need compare is done at 6 bits so it cannot wrap.
- passage and passage_len hold their values in IDLE until the next accepted req. passage_len is not updated mid-build; it changes only in DONE.
- A req while busy is ignored; no queuing.
- A reset mid-build aborts immediately to reset values. No done pulse is produced.
- dict_id holds its last value outside PICK.

Optional Feature:
- NO_REPEAT_EN
  - Defined: in FETCH, a candidate equal to the id of the previously accepted word in the same build is rejected like a zero-length word. It increments reject_cnt and is subject to MAX_REJECT.
  - Undefined: repeats are allowed; no previous-id register is built.

Test Plan:
- Dictionary model returns "abcd" (1,2,3,4), len 4, for every id; req → 5 words, passage_len=24, chars 0..3 = 1,2,3,4, slot 4 = 27, slot 24 = 0, one done pulse.
- Model returns len 12 for all ids → 2 words plus separator; passage_len=25, slot 12 = 27, stops on pos==SLOTS.
- Model returns len 0 for all ids → done after exactly 8 PICK/FETCH rounds; passage_len=0, passage all zero.
- MAX_WORDS=2 with len-3 words → passage_len=7, done pulse; a second req pulse issued mid-build is ignored (exactly one done, busy never drops early).
- Assert rst during COPY of the 2nd word → outputs go to reset values the same edge, no done. Then req → full build matches the case-1 result.
- With NO_REPEAT_EN defined and a model whose word depends on id → no two adjacent words in passage share an id. A dictionary with a single valid id yields passage_len equal to that word's length.

Source files
------------

// File: rtl/passage_builder.sv
// passage_builder: picks random dictionary words via an LFSR and packs them,
// space separated, into a SLOTS-character passage buffer for a typing round.
// Ports: clk, rst (async, active-high), req (build pulse), dict_id/dict_word/
// dict_len (dictionary lookup), passage/passage_len (result), busy, done.
// Optional: define NO_REPEAT_EN to reject a pick equal to the last accepted id.
module passage_builder #(
  parameter int          SLOTS      = 25,
  parameter int          MAX_WORDS  = 8,
  parameter int          MAX_REJECT = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  output logic [4:0]         dict_id,
  input  logic [74:0]        dict_word,
  input  logic [3:0]         dict_len,
  output logic [5*SLOTS-1:0] passage,
  output logic [4:0]         passage_len,
  output logic               busy,
  output logic               done
);

  localparam int WW  = $clog2(MAX_WORDS + 1);
  localparam int RW  = $clog2(MAX_REJECT + 1);
  localparam int PIW = $clog2(5 * SLOTS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PICK  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SPACE = 3'd3;
  localparam logic [2:0] S_COPY  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [15:0]        lfsr_q;
  logic [4:0]         id_q, id_d;
  logic [74:0]        word_q, word_d;
  logic [3:0]         len_q, len_d;
  logic [4:0]         pos_q, pos_d;
  logic [3:0]         k_q, k_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [RW-1:0]      rej_q, rej_d;
  logic [5*SLOTS-1:0] pass_q, pass_d;
  logic [4:0]         plen_q, plen_d;

  logic [5:0]     fit;
  logic           reject;
  logic [6:0]     kidx;
  logic [PIW-1:0] pidx;

`ifdef NO_REPEAT_EN
  logic [4:0] prev_q, prev_d;
  logic       pvld_q, pvld_d;
  assign reject = (dict_len == 4'd0) || (pvld_q && (id_q == prev_q));
`else
  assign reject = (dict_len == 4'd0);
`endif

  // 6-bit sum so the fit check cannot wrap
  assign fit  = {1'b0, pos_q} + {2'b00, dict_len}
              + {5'd0, (wcnt_q != '0)};
  assign kidx = 7'(k_q) * 7'd5;
  assign pidx = PIW'(pos_q) * PIW'(5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[14:0],
                        lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    word_d  = word_q;
    len_d   = len_q;
    pos_d   = pos_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    rej_d   = rej_q;
    pass_d  = pass_q;
    plen_d  = plen_q;
`ifdef NO_REPEAT_EN
    prev_d  = prev_q;
    pvld_d  = pvld_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          pass_d  = '0;
          pos_d   = '0;
          wcnt_d  = '0;
          rej_d   = '0;
`ifdef NO_REPEAT_EN
          pvld_d  = 1'b0;
`endif
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        id_d    = lfsr_q[4:0];
        state_d = S_FETCH;
      end
      S_FETCH: begin
        word_d = dict_word;
        len_d  = dict_len;
        k_d    = '0;
        if (reject) begin
          rej_d = rej_q + 1'b1;
          if (rej_q + 1'b1 == RW'(MAX_REJECT)) state_d = S_DONE;
          else                                 state_d = S_PICK;
        end else if (fit > 6'(SLOTS)) begin
          state_d = S_DONE;
        end else begin
          rej_d = '0;
`ifdef NO_REPEAT_EN
          prev_d = id_q;
          pvld_d = 1'b1;
`endif
          state_d = (wcnt_q != '0) ? S_SPACE : S_COPY;
        end
      end
      S_SPACE: begin
        pass_d[pidx +: 5] = 5'd27;
        pos_d   = pos_q + 5'd1;
        state_d = S_COPY;
      end
      S_COPY: begin
        pass_d[pidx +: 5] = word_q[kidx +: 5];
        pos_d = pos_q + 5'd1;
        k_d   = k_q + 4'd1;
        if (k_q == len_q - 4'd1) begin
          wcnt_d = wcnt_q + 1'b1;
          if ((wcnt_q + 1'b1 == WW'(MAX_WORDS)) ||
              (pos_q + 5'd1 == 5'(SLOTS)))
            state_d = S_DONE;
          else
            state_d = S_PICK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // length is published together with the done pulse
    if (state_d == S_DONE) plen_d = pos_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      word_q  <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      k_q     <= '0;
      wcnt_q  <= '0;
      rej_q   <= '0;
      pass_q  <= '0;
      plen_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      word_q  <= word_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      rej_q   <= rej_d;
      pass_q  <= pass_d;
      plen_q  <= plen_d;
    end
  end

`ifdef NO_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pvld_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pvld_q <= pvld_d;
    end
  end
`endif

  assign dict_id     = id_q;
  assign passage     = pass_q;
  assign passage_len = plen_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_passage_builder.sv
// Scoreboard bench for passage_builder: directed dictionary patterns,
// expected passages queued at request time and checked on each done pulse.
module tb_passage_builder;

  typedef struct {
    logic [124:0] p;
    logic [4:0]   len;
    int           lat;
    bit           exact;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [4:0]   did0, did1;
  logic [74:0]  dw0, dw1;
  logic [3:0]   dl0, dl1;
  logic [124:0] pas0, pas1;
  logic [4:0]   pl0, pl1;
  logic         busy0, busy1, done0, done1;

  int   mode = 0;
  logic fset = 1'b0;
  logic [4:0] fid = '0;
  int   nvec = 0, nerr = 0;
  int   bc0 = 0, bc1 = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  passage_builder u0 (
    .clk(clk), .rst(rst), .req(req0), .dict_id(did0),
    .dict_word(dw0), .dict_len(dl0), .passage(pas0),
    .passage_len(pl0), .busy(busy0), .done(done0));

  passage_builder #(.MAX_WORDS(2)) u1 (
    .clk(clk), .rst(rst), .req(req1), .dict_id(did1),
    .dict_word(dw1), .dict_len(dl1), .passage(pas1),
    .passage_len(pl1), .busy(busy1), .done(done1));

  function automatic logic [78:0] dm(int m, logic [4:0] id,
                                     logic fs, logic [4:0] fi);
    logic [74:0] w;
    logic [3:0]  l;
    w = '1;
    case (m)
      0: l = 4'd4;
      1: l = 4'd12;
      2: l = 4'd0;
      3: l = 4'd3;
      5: l = (fs && id == fi) ? 4'd3 : 4'd0;
      default: l = 4'd2;
    endcase
    for (int k = 0; k < 15; k++)
      if (k < int'(l)) w[5*k +: 5] = 5'(k + 1);
    if (m == 4) begin
      w[4:0] = {2'b0, id[2:0]} + 5'd1;
      w[9:5] = {3'b0, id[4:3]} + 5'd1;
    end
    return {l, w};
  endfunction

  always_comb {dl0, dw0} = dm(mode, did0, fset, fid);
  always_comb {dl1, dw1} = dm(mode, did1, fset, fid);

  function automatic logic [124:0] pk(string s);
    logic [124:0] r;
    logic [7:0]   c;
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      r[5*i +: 5] = (c == " ") ? 5'd27 : 5'(c - 8'd96);
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp(string nm, exp_t e, logic [124:0] p,
                     logic [4:0] l, int bc);
    if (e.exact) begin
      chk({nm, "_passage"}, 128'(p), 128'(e.p));
      chk({nm, "_len"}, 128'(l), 128'(e.len));
    end
    if (e.lat >= 0) chk({nm, "_cycles"}, 128'(bc), 128'(e.lat));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy0) bc0++;
    if (done0) begin
      if (q0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL u0_unexpected_done got=1 want=0");
      end else begin
        e = q0.pop_front();
        cmp("u0", e, pas0, pl0, bc0);
      end
      bc0 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy1) bc1++;
    if (done1) begin
      if (q1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL u1_unexpected_done got=1 want=0");
      end else begin
        e = q1.pop_front();
        cmp("u1", e, pas1, pl1, bc1);
      end
      bc1 = 0;
    end
  end

  task automatic push0(string s, int l, int lat, bit ex);
    exp_t e;
    e.p = pk(s); e.len = 5'(l); e.lat = lat; e.exact = ex;
    q0.push_back(e);
  endtask

  task automatic pulse(int which);
    @(posedge clk); #2;
    if (which == 0) req0 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #2;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (!busy0 && !busy1 && q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL %s_timeout got=busy want=idle", nm);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t e1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", 128'({busy0, busy1}), 128'(0));
    chk("rst_done", 128'({done0, done1}), 128'(0));
    chk("rst_plen", 128'({pl0, pl1}), 128'(0));
    chk("rst_pass", 128'(pas0 | pas1), 128'(0));
    chk("rst_id", 128'({did0, did1}), 128'(0));

    mode = 0;
    push0("abcd abcd abcd abcd abcd", 24, 37, 1'b1);
    pulse(0);
    wait_idle("abcd");
    repeat (5) @(posedge clk);
    #1;
    chk("hold_len", 128'(pl0), 128'(24));
    chk("hold_pass", 128'(pas0), 128'(pk("abcd abcd abcd abcd abcd")));

    mode = 1;
    push0("abcdefghijkl abcdefghijkl", 25, 30, 1'b1);
    pulse(0);
    wait_idle("len12");

    mode = 2;
    push0("", 0, 17, 1'b1);
    pulse(0);
    wait_idle("len0");

    mode = 3;
    e1.p = pk("abc abc"); e1.len = 5'd7; e1.lat = 12; e1.exact = 1'b1;
    q1.push_back(e1);
    pulse(1);
    repeat (3) @(posedge clk);
    pulse(1);
    wait_idle("maxw");
    #1 chk("maxw_hold", 128'(pl1), 128'(7));

    mode = 0;
    pulse(0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy0), 128'(0));
    chk("abort_done", 128'(done0), 128'(0));
    chk("abort_plen", 128'({pl0, pl1}), 128'(0));
    chk("abort_pass", 128'(pas0), 128'(0));
    chk("abort_id", 128'(did0), 128'(0));
    bc0 = 0; bc1 = 0;
    @(posedge clk); #2 rst = 1'b0;
    push0("abcd abcd abcd abcd abcd", 24, 37, 1'b1);
    pulse(0);
    wait_idle("rebuild");

`ifdef NO_REPEAT_EN
    mode = 4;
    push0("", 0, -1, 1'b0);
    pulse(0);
    wait_idle("norep");
    for (int i = 1; i < (int'(pl0) + 1) / 3; i++) begin
      nvec++;
      if (pas0[15*i +: 10] == pas0[15*(i-1) +: 10]) begin
        nerr++;
        $display("FAIL norep_adjacent got=%0h want=different",
                 pas0[15*i +: 10]);
      end
    end

    mode = 5;
    fset = 1'b0;
    push0("abc", 3, -1, 1'b1);
    @(posedge clk); #2 req0 = 1'b1;
    @(posedge clk); #2 req0 = 1'b0;
    @(posedge clk); #1;
    fid = did0; fset = 1'b1;
    wait_idle("single");
`endif

    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q1_drained", 128'(q1.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
